// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side burst consumer.
// Imported by the top and the output skid buffer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer carrying {data, last}.
// Head entry drives the output and holds steady while not accepted.
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_150_0,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_valid,
  output logic [1:0]        buf_cnt
);

  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic              l0;
  logic              l1;
  logic              pop;
  logic [1:0]        fill;

  assign rd_valid = (buf_cnt != 2'd0);
  assign rd_data  = d0;
  assign rd_last  = l0;
  assign pop      = rd_valid && rd_ready;
  // occupancy once this cycle's pop has left; the write lands there
  assign fill     = buf_cnt - {1'b0, pop};

  always_ff @(posedge clk_150_0) begin
    if (rst) begin
      d0      <= '0;
      d1      <= '0;
      l0      <= 1'b0;
      l1      <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (pop) begin
        d0 <= d1;
        l0 <= l1;
      end
      if (wr_en && fill == 2'd0) begin
        d0 <= wr_data;
        l0 <= wr_last;
      end
      if (wr_en && fill == 2'd1) begin
        d1 <= wr_data;
        l1 <= wr_last;
      end
      buf_cnt <= fill + {1'b0, wr_en};
    end
  end

  ovf_chk: assert property (
    @(posedge clk_150_0) disable iff (rst)
    !(wr_en && fill == 2'(OBUF_DEPTH))
  );

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer of the dual-clock FIFO.
// Credit-limited rdreq keeps the 2-entry output buffer from overflowing.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int USEDW_W   = 3,
  parameter int BURST_LEN = 4
) (
  input  logic               clk_150_0,
  input  logic               rst,
  input  logic               rdempty,
  input  logic               rdfull,
  input  logic [USEDW_W-1:0] rdusedw,
  input  logic [DATA_W-1:0]  q,
  output logic               rdreq,
  input  logic               flush,
  output logic [DATA_W-1:0]  dout,
  output logic               dout_valid,
  output logic               dout_last,
  input  logic               dout_ready,
  output logic               busy
);

  localparam int OCC_W = USEDW_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(2 ** USEDW_W);
  localparam logic [OCC_W-1:0] BLEN = OCC_W'(BURST_LEN);

  state_t           state;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] len;
  logic [OCC_W-1:0] cnt;
  logic             rd_pend;
  logic             pend_last;
  logic [1:0]       buf_cnt;
  logic             pop;
  logic [2:0]       inflight;
  logic             credit;
  logic             is_last;

  // rdusedw wraps to zero when the FIFO is full
  assign occ      = rdfull ? FULL_OCC : {1'b0, rdusedw};
  assign pop      = dout_valid && dout_ready;
  assign inflight = {1'b0, buf_cnt} + {2'b0, rd_pend} - {2'b0, pop};
  assign credit   = inflight < 3'(OBUF_DEPTH);
  assign rdreq    = (state == BURST) && !rdempty && credit;
  assign is_last  = (cnt == len - OCC_W'(1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_150_0) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      rd_pend   <= rdreq;
      pend_last <= rdreq && is_last;
      unique case (state)
        IDLE: begin
          if (occ >= BLEN) begin
            len   <= BLEN;
            cnt   <= '0;
            state <= BURST;
          end else if (flush && !rdempty && occ != '0) begin
            len   <= occ;
            cnt   <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (rdreq) begin
            cnt <= cnt + OCC_W'(1);
            if (is_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!rd_pend && buf_cnt == 2'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_obuf (
    .clk_150_0 (clk_150_0),
    .rst       (rst),
    .wr_en     (rd_pend),
    .wr_data   (q),
    .wr_last   (pend_last),
    .rd_ready  (dout_ready),
    .rd_data   (dout),
    .rd_last   (dout_last),
    .rd_valid  (dout_valid),
    .buf_cnt   (buf_cnt)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, stream monitor,
// and a burst-rule reference of the expected output stream.
module tb_fifo_burst_reader;

  logic        clk_150_0 = 1'b0;
  logic        rst = 1'b1;
  logic        rdempty;
  logic        rdfull;
  logic [2:0]  rdusedw;
  logic [15:0] q = '0;
  logic        rdreq;
  logic        flush = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_ready = 1'b0;
  logic        busy;

  always #5 clk_150_0 = ~clk_150_0;

  fifo_burst_reader #(
    .DATA_W    (16),
    .USEDW_W   (3),
    .BURST_LEN (4)
  ) dut (
    .clk_150_0  (clk_150_0),
    .rst        (rst),
    .rdempty    (rdempty),
    .rdfull     (rdfull),
    .rdusedw    (rdusedw),
    .q          (q),
    .rdreq      (rdreq),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  // FIFO model: 8 words, non-showahead
  logic [15:0] mem [0:7];
  int          wp = 0;
  int          rp = 0;
  int          fcnt;
  logic        ovr_en = 1'b0;
  logic [2:0]  ovr_val = 3'd0;

  assign fcnt = wp - rp;

  always_comb begin
    rdempty = (fcnt == 0);
    rdfull  = !ovr_en && (fcnt >= 8);
    rdusedw = ovr_en ? ovr_val : fcnt[2:0];
  end

  always @(posedge clk_150_0) begin
    if (rdreq && fcnt > 0) begin
      q  <= mem[rp % 8];
      rp <= rp + 1;
    end
  end

  // monitor
  int          cyc = 0;
  int          nreq = 0;
  int          nacc = 0;
  int          drop = 0;
  int          max_held = 0;
  int          stall_req = 0;
  int          unstable = 0;
  int          req_cyc[$];
  int          acc_cyc[$];
  logic [16:0] obs[$];
  logic [16:0] expq[$];
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        pl = 1'b0;
  logic [15:0] pd = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk_150_0) begin
    int held;
    cyc++;
    held = nreq - nacc - drop;
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (held > max_held) max_held = held;
      if (rdreq && !dout_ready && held >= 2) stall_req++;
      if (pv && !pr && (!dout_valid || dout !== pd || dout_last !== pl))
        unstable++;
      if (rdreq) begin
        nreq++;
        req_cyc.push_back(cyc);
      end
      if (dout_valid && dout_ready) begin
        nacc++;
        obs.push_back({dout_last, dout});
        acc_cyc.push_back(cyc);
      end
      pv = dout_valid;
      pr = dout_ready;
      pd = dout;
      pl = dout_last;
    end
  end

  // reference: words leave in FIFO order, last on every blen-th word
  // and on the final word of the group
  function automatic void model_stream(input logic [15:0] w[$], input int blen);
    logic lst;
    for (int i = 0; i < w.size(); i++) begin
      lst = ((i % blen) == blen - 1) || (i == w.size() - 1);
      expq.push_back({lst, w[i]});
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_150_0);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    mem[wp % 8] = d;
    wp++;
  endtask

  task automatic wait_words(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs.size() >= target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dout_ready = 1'b0;
    tick(3);
    n_cmp++;
    if (rdreq !== 1'b0) begin
      n_bad++; $display("FAIL rst_rdreq: got %b want 0", rdreq);
    end
    n_cmp++;
    if (dout_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid: got %b want 0", dout_valid);
    end
    n_cmp++;
    if (dout_last !== 1'b0) begin
      n_bad++; $display("FAIL rst_last: got %b want 0", dout_last);
    end
    n_cmp++;
    if (dout !== 16'h0) begin
      n_bad++; $display("FAIL rst_dout: got %h want 0000", dout);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    logic [15:0] w[$];
    int s, r0, rq0;
    bit ok, ok2;
    s = obs.size(); r0 = nreq; rq0 = req_cyc.size();
    w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    dout_ready = 1'b1;
    foreach (w[i]) push(w[i]);
    model_stream(w, 4);
    wait_words(s + 4, 40, ok);
    wait_idle(20, ok2);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL basic_done: got %0d words want 4", obs.size() - s);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs[s+i] !== expq[s+i]) begin
          n_bad++;
          $display("FAIL basic_w%0d: got %h want %h", i, obs[s+i], expq[s+i]);
        end
      end
      n_cmp++;
      if (acc_cyc[s+3] - acc_cyc[s] != 3) begin
        n_bad++;
        $display("FAIL basic_tput: got span %0d want 3", acc_cyc[s+3] - acc_cyc[s]);
      end
    end
    n_cmp++;
    if (!ok2) begin
      n_bad++; $display("FAIL basic_busy: got busy %b want 0", busy);
    end
    tick(5);
    n_cmp++;
    if (nreq - r0 != 4) begin
      n_bad++; $display("FAIL basic_nreq: got %0d want 4", nreq - r0);
    end else begin
      n_cmp++;
      if (req_cyc[rq0+3] - req_cyc[rq0] != 3) begin
        n_bad++;
        $display("FAIL basic_reqspan: got %0d want 3", req_cyc[rq0+3] - req_cyc[rq0]);
      end
    end
  endtask

  task automatic test_flush();
    logic [15:0] w[$];
    int s, r0;
    bit ok, ok2;
    s = obs.size(); r0 = nreq;
    w = '{16'h00a1, 16'h00a2, 16'h00a3};
    foreach (w[i]) push(w[i]);
    tick(50);
    n_cmp++;
    if (nreq != r0) begin
      n_bad++; $display("FAIL flush_hold: got %0d reads want 0", nreq - r0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle: got busy %b want 0", busy);
    end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    model_stream(w, 3);
    wait_words(s + 3, 40, ok);
    wait_idle(20, ok2);
    tick(5);
    n_cmp++;
    if (!ok || !ok2) begin
      n_bad++; $display("FAIL flush_done: got %0d words want 3", obs.size() - s);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs[s+i] !== expq[s+i]) begin
          n_bad++;
          $display("FAIL flush_w%0d: got %h want %h", i, obs[s+i], expq[s+i]);
        end
      end
    end
    n_cmp++;
    if (nreq - r0 != 3) begin
      n_bad++; $display("FAIL flush_nreq: got %0d want 3", nreq - r0);
    end
  endtask

  task automatic test_full();
    logic [15:0] w[$];
    int s, r0, rq0;
    bit ok, ok2;
    s = obs.size(); r0 = nreq; rq0 = req_cyc.size();
    for (int i = 0; i < 8; i++) w.push_back(16'($urandom));
    foreach (w[i]) push(w[i]);
    model_stream(w, 4);
    wait_words(s + 8, 80, ok);
    wait_idle(20, ok2);
    tick(5);
    n_cmp++;
    if (!ok || !ok2 || nreq - r0 != 8) begin
      n_bad++; $display("FAIL full_done: got %0d reads want 8", nreq - r0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (obs[s+i] !== expq[s+i]) begin
          n_bad++;
          $display("FAIL full_w%0d: got %h want %h", i, obs[s+i], expq[s+i]);
        end
      end
      n_cmp++;
      if (req_cyc[rq0+4] - req_cyc[rq0+3] < 3) begin
        n_bad++;
        $display("FAIL full_gap: got %0d want >=3", req_cyc[rq0+4] - req_cyc[rq0+3]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w[$];
    int s;
    bit ok, ok2;
    s = obs.size();
    w = '{16'h0b01, 16'h0b02, 16'h0b03, 16'h0b04};
    dout_ready = 1'b1;
    foreach (w[i]) push(w[i]);
    model_stream(w, 4);
    wait_words(s + 1, 20, ok);
    dout_ready = 1'b0;
    tick(10);
    n_cmp++;
    if (rdreq !== 1'b0 || dout_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stall: got rdreq %b valid %b want 0 1", rdreq, dout_valid);
    end
    dout_ready = 1'b1;
    wait_words(s + 4, 40, ok2);
    n_cmp++;
    if (!ok || !ok2) begin
      n_bad++; $display("FAIL bp_done: got %0d words want 4", obs.size() - s);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs[s+i] !== expq[s+i]) begin
          n_bad++;
          $display("FAIL bp_w%0d: got %h want %h", i, obs[s+i], expq[s+i]);
        end
      end
    end
    n_cmp++;
    if (max_held > 2 || stall_req != 0 || unstable != 0) begin
      n_bad++;
      $display("FAIL bp_rules: got held %0d req %0d unst %0d want <=2 0 0",
               max_held, stall_req, unstable);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_empty_wait();
    logic [15:0] w[$];
    int s, r0;
    bit ok, ok2;
    s = obs.size(); r0 = nreq;
    w = '{16'h0c01, 16'h0c02, 16'h0c03, 16'h0c04};
    dout_ready = 1'b1;
    push(w[0]);
    push(w[1]);
    ovr_val = 3'd4;
    ovr_en = 1'b1;
    tick(1);
    ovr_en = 1'b0;
    tick(8);
    n_cmp++;
    if (nreq - r0 != 2 || busy !== 1'b1 || rdreq !== 1'b0) begin
      n_bad++;
      $display("FAIL ew_hold: got reads %0d busy %b rdreq %b want 2 1 0",
               nreq - r0, busy, rdreq);
    end
    push(w[2]);
    push(w[3]);
    model_stream(w, 4);
    wait_words(s + 4, 40, ok);
    wait_idle(20, ok2);
    n_cmp++;
    if (!ok || !ok2) begin
      n_bad++; $display("FAIL ew_done: got %0d words want 4", obs.size() - s);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs[s+i] !== expq[s+i]) begin
          n_bad++;
          $display("FAIL ew_w%0d: got %h want %h", i, obs[s+i], expq[s+i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] w[$];
    int s, k;
    bit ok, ok2;
    s = obs.size();
    k = 0;
    for (int i = 0; i < 16; i++) w.push_back(16'($urandom));
    model_stream(w, 4);
    for (int c = 0; c < 3000 && obs.size() < s + 16; c++) begin
      if (k < 16 && fcnt < 8 && $urandom_range(0, 1) == 1) begin
        push(w[k]);
        k++;
      end
      dout_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    dout_ready = 1'b1;
    ok = (obs.size() >= s + 16);
    wait_idle(20, ok2);
    n_cmp++;
    if (!ok || !ok2) begin
      n_bad++; $display("FAIL rnd_done: got %0d words want 16", obs.size() - s);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (obs[s+i] !== expq[s+i]) begin
          n_bad++;
          $display("FAIL rnd_w%0d: got %h want %h", i, obs[s+i], expq[s+i]);
        end
      end
    end
    n_cmp++;
    if (max_held > 2 || stall_req != 0 || unstable != 0) begin
      n_bad++;
      $display("FAIL rnd_rules: got held %0d req %0d unst %0d want <=2 0 0",
               max_held, stall_req, unstable);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w[$];
    int s;
    bit ok, ok2;
    s = obs.size();
    dout_ready = 1'b1;
    push(16'h0051); push(16'h0052); push(16'h0053); push(16'h0054);
    tick(1);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    drop = nreq - nacc;
    n_cmp++;
    if (rdreq !== 1'b0 || dout_valid !== 1'b0 || dout_last !== 1'b0 ||
        dout !== 16'h0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_outs: got rdreq %b valid %b last %b dout %h busy %b want 0",
               rdreq, dout_valid, dout_last, dout, busy);
    end
    n_cmp++;
    if (obs.size() != s) begin
      n_bad++; $display("FAIL rm_leak: got %0d words want 0", obs.size() - s);
    end
    w = '{16'h0053, 16'h0054, 16'h0055, 16'h0056};
    push(16'h0055); push(16'h0056);
    model_stream(w, 4);
    wait_words(s + 4, 40, ok);
    wait_idle(20, ok2);
    n_cmp++;
    if (!ok || !ok2) begin
      n_bad++; $display("FAIL rm_done: got %0d words want 4", obs.size() - s);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs[s+i] !== expq[s+i]) begin
          n_bad++;
          $display("FAIL rm_w%0d: got %h want %h", i, obs[s+i], expq[s+i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_full();
    test_backpressure();
    test_empty_wait();
    test_random();
    test_reset_mid();
    tick(10);
    n_cmp++;
    if (obs.size() != expq.size()) begin
      n_bad++;
      $display("FAIL stream_len: got %0d words want %0d", obs.size(), expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
